// File: rtl/uart_rx_tick_gen_pkg.sv
// rtl/uart_rx_tick_gen_pkg.sv - shared types, default widths and divisor helper for the RX tick generator
package uart_pkg;

  localparam int DEF_CLK_HZ = 50_000_000;
  localparam int DEF_BAUD   = 9600;
  localparam int DEF_OSR    = 9;
  localparam int DEF_FRAC_W = 8;
  localparam int DEF_DIV_W  = 16;

  localparam int PHASE_W = $clog2(DEF_OSR);
  localparam int DIVW_T  = DEF_DIV_W + DEF_FRAC_W;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Rounded fixed-point clocks per sample tick: clk * 2^frac / (baud * osr)
  function automatic longint calc_def_div(input longint clk_hz, input longint baud,
                                          input longint osr, input int frac_w);
    longint num;
    longint den;
    num = clk_hz << frac_w;
    den = baud * osr;
    return (2 * num + den) / (2 * den);
  endfunction

endpackage

// File: rtl/uart_rx_tick_gen_if.sv
// rtl/uart_rx_tick_gen_if.sv - control and tick-strobe bundle between the RX edge detector, frame FSM and tick generator
interface uart_rx_tick_gen_if
  import uart_pkg::*;
#(
  parameter int DW = DIVW_T,
  parameter int PW = PHASE_W
);
  logic          rx_start;
  logic          rx_done;
  logic          resync;
  logic          cfg_load;
  logic [DW-1:0] cfg_div;
  logic          busy;
  logic          sample_tick;
  logic          mid_tick;
  logic          bit_tick;
  logic [PW-1:0] phase;

  modport master (
    output rx_start, rx_done, resync, cfg_load, cfg_div,
    input  busy, sample_tick, mid_tick, bit_tick, phase
  );

  modport slave (
    input  rx_start, rx_done, resync, cfg_load, cfg_div,
    output busy, sample_tick, mid_tick, bit_tick, phase
  );
endinterface

// File: rtl/uart_rx_tick_gen_frac_divider.sv
// rtl/uart_rx_tick_gen_frac_divider.sv - fractional clock divider producing a raw tick every I or I+1 cycles
module uart_frac_divider
  import uart_pkg::*;
#(
  parameter int DIV_W  = DEF_DIV_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              tick
);
  logic [DIV_W-1:0]  cnt;
  logic [FRAC_W-1:0] frac_acc;
  logic              carry;
  logic              hit;

  // Period is I + carry; compare cnt+1 against it with one spare bit so I=max never wraps
  assign hit  = ({1'b0, cnt} + (DIV_W+1)'(1)) == ({1'b0, div_int} + (DIV_W+1)'(carry));
  assign tick = en && !clr && hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      frac_acc <= '0;
      carry    <= 1'b0;
    end else if (clr) begin
      cnt      <= '0;
      frac_acc <= '0;
      carry    <= 1'b0;
    end else if (en) begin
      if (hit) begin
        cnt               <= '0;
        {carry, frac_acc} <= (FRAC_W+1)'(frac_acc) + (FRAC_W+1)'(div_frac);
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end
endmodule

// File: rtl/uart_rx_tick_gen.sv
// rtl/uart_rx_tick_gen.sv - oversampling tick generator with phase tracking and mid/end-of-bit strobes for the UART RX path
module uart_rx_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQUENCE = DEF_CLK_HZ,
  parameter int BAUD_RATE     = DEF_BAUD,
  parameter int OSR           = DEF_OSR,
  parameter int FRAC_W        = DEF_FRAC_W,
  parameter int DIV_W         = DEF_DIV_W
) (
  input  logic               clk,
  input  logic               rst,
  uart_rx_tick_gen_if.slave  bus
);
  localparam int PW = $clog2(OSR);
  localparam int DW = DIV_W + FRAC_W;
  localparam logic [DW-1:0] DEF_DIV =
    DW'(calc_def_div(longint'(CLK_FREQUENCE), longint'(BAUD_RATE), longint'(OSR), FRAC_W));
  localparam logic [PW-1:0] PH_LAST = PW'(OSR - 1);
  localparam logic [PW-1:0] PH_MID  = PW'(OSR / 2);

  state_t            state;
  state_t            state_nxt;
  logic [DW-1:0]     div_reg;
  logic [PW-1:0]     phase_cnt;
  logic              raw_tick;
  logic              tick_ok;
  logic              div_clr;
  logic              div_en;
  logic [DIV_W-1:0]  load_int;
  logic [DIV_W-1:0]  load_int_clamped;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // rx_done outranks resync, which outranks a tick due on the same edge
  always_comb begin
    state_nxt = state;
    div_clr   = 1'b0;
    div_en    = 1'b0;
    tick_ok   = 1'b0;
    case (state)
      IDLE: begin
        div_clr = 1'b1;
        if (bus.rx_start) state_nxt = RUN;
      end
      RUN: begin
        div_en  = 1'b1;
        div_clr = bus.rx_done || bus.resync;
        tick_ok = raw_tick;
        if (bus.rx_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Integer part below 2 would allow back-to-back ticks
  assign load_int         = bus.cfg_div[DW-1:FRAC_W];
  assign load_int_clamped = (load_int < DIV_W'(2)) ? DIV_W'(2) : load_int;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                div_reg <= DEF_DIV;
    else if (state == IDLE && bus.cfg_load) div_reg <= {load_int_clamped, bus.cfg_div[FRAC_W-1:0]};
  end

  uart_frac_divider #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .clr      (div_clr),
    .en       (div_en),
    .div_int  (div_reg[DW-1:FRAC_W]),
    .div_frac (div_reg[FRAC_W-1:0]),
    .tick     (raw_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_cnt       <= '0;
      bus.busy        <= 1'b0;
      bus.sample_tick <= 1'b0;
      bus.mid_tick    <= 1'b0;
      bus.bit_tick    <= 1'b0;
      bus.phase       <= '0;
    end else begin
      bus.busy        <= (state_nxt == RUN);
      bus.sample_tick <= tick_ok;
      bus.mid_tick    <= tick_ok && (phase_cnt == PH_MID);
      bus.bit_tick    <= tick_ok && (phase_cnt == PH_LAST);
      if (tick_ok) bus.phase <= phase_cnt;
      if (div_clr)      phase_cnt <= '0;
      else if (tick_ok) phase_cnt <= (phase_cnt == PH_LAST) ? '0 : phase_cnt + PW'(1);
    end
  end
endmodule

// File: tb/tb_uart_rx_tick_gen.sv
// tb/tb_uart_rx_tick_gen.sv - scoreboard bench for uart_rx_tick_gen with OSR 9 and OSR 4 instances
module tb_uart_rx_tick_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_start = 1'b0;
  logic        rx_done = 1'b0;
  logic        resync = 1'b0;
  logic        cfg_load = 1'b0;
  logic [23:0] cfg_div = '0;
  int          sel = 0;
  int          cyc = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  typedef struct {
    int t;
    int ph;
    int md;
    int bt;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   tt0[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_tick_gen_if #(.DW(24), .PW(4)) b9 ();
  uart_rx_tick_gen_if #(.DW(24), .PW(2)) b4 ();

  assign b9.rx_start = rx_start && (sel == 0);
  assign b9.rx_done  = rx_done  && (sel == 0);
  assign b9.resync   = resync   && (sel == 0);
  assign b9.cfg_load = cfg_load && (sel == 0);
  assign b9.cfg_div  = cfg_div;
  assign b4.rx_start = rx_start && (sel == 1);
  assign b4.rx_done  = rx_done  && (sel == 1);
  assign b4.resync   = resync   && (sel == 1);
  assign b4.cfg_load = cfg_load && (sel == 1);
  assign b4.cfg_div  = cfg_div;

  uart_rx_tick_gen #(.OSR(9)) u9 (.clk(clk), .rst(rst), .bus(b9));
  uart_rx_tick_gen #(.OSR(4)) u4 (.clk(clk), .rst(rst), .bus(b4));

  task automatic chk(input string name, input longint act, input longint req);
    total_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: actual %0d required %0d", name, act, req);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (b9.sample_tick) begin
      if (q0.size() == 0) chk("tick9_unexpected_cycle", cyc, -1);
      else begin
        e = q0.pop_front();
        chk("tick9_cycle", cyc, e.t);
        chk("tick9_phase", b9.phase, e.ph);
        chk("tick9_mid", b9.mid_tick, e.md);
        chk("tick9_bit", b9.bit_tick, e.bt);
      end
      tt0.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b4.sample_tick) begin
      if (q1.size() == 0) chk("tick4_unexpected_cycle", cyc, -1);
      else begin
        e = q1.pop_front();
        chk("tick4_cycle", cyc, e.t);
        chk("tick4_phase", b4.phase, e.ph);
        chk("tick4_mid", b4.mid_tick, e.md);
        chk("tick4_bit", b4.bit_tick, e.bt);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic int qsize();
    return (sel != 0) ? q1.size() : q0.size();
  endfunction

  // Tick k after a start/resync edge s lands at s + k*I + floor((k-1)*F/256)
  task automatic push_ticks(input int s, input int i_div, input int f_div, input int n);
    for (int k = 1; k <= n; k++) begin
      exp_t e;
      int   o;
      o    = (sel != 0) ? 4 : 9;
      e.t  = s + k * i_div + ((k - 1) * f_div) / 256;
      e.ph = (k - 1) % o;
      e.md = (e.ph == o / 2) ? 1 : 0;
      e.bt = (e.ph == o - 1) ? 1 : 0;
      if (sel != 0) q1.push_back(e);
      else          q0.push_back(e);
    end
  endtask

  task automatic start_run(input int i_div, input int f_div, input int n, output int s);
    s        = cyc + 1;
    rx_start = 1'b1;
    push_ticks(s, i_div, f_div, n);
    step();
    rx_start = 1'b0;
    chk("busy_after_start", (sel != 0) ? b4.busy : b9.busy, 1);
  endtask

  task automatic end_run();
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
    chk("busy_after_done", (sel != 0) ? b4.busy : b9.busy, 0);
  endtask

  task automatic drain(input string name, input int limit);
    int n;
    n = 0;
    while (qsize() != 0 && n < limit) begin
      step();
      n++;
    end
    chk({name, "_pending_ticks"}, qsize(), 0);
    q0.delete();
    q1.delete();
  endtask

  task automatic load(input logic [23:0] val);
    cfg_div  = val;
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  initial begin
    int s;
    int nl;
    int ns;

    repeat (3) step();
    chk("rst_busy9", b9.busy, 0);
    chk("rst_tick9", b9.sample_tick, 0);
    chk("rst_mid9", b9.mid_tick, 0);
    chk("rst_bit9", b9.bit_tick, 0);
    chk("rst_phase9", b9.phase, 0);
    chk("rst_busy4", b4.busy, 0);
    rst = 1'b0;
    step();

    // Defaults: I=578, F=180, OSR 9
    sel = 0;
    start_run(578, 180, 20, s);
    drain("default", 20 * 600);
    end_run();

    // Load with start in the same cycle, then long-run drift over 256 intervals
    tt0.delete();
    cfg_div  = {16'd5, 8'd180};
    cfg_load = 1'b1;
    start_run(5, 180, 257, s);
    cfg_load = 1'b0;
    drain("drift", 257 * 7);
    end_run();
    chk("drift_tick_count", tt0.size(), 257);
    nl = 0;
    ns = 0;
    for (int k = 1; k < tt0.size(); k++) begin
      if (tt0[k] - tt0[k-1] == 6) nl++;
      if (tt0[k] - tt0[k-1] == 5) ns++;
    end
    chk("drift_long_periods", nl, 180);
    chk("drift_short_periods", ns, 76);
    if (tt0.size() == 257) chk("drift_span", tt0[256] - tt0[0], 1460);

    // OSR 4, I=4, F=128
    sel = 1;
    load({16'd4, 8'd128});
    start_run(4, 128, 12, s);
    drain("osr4", 100);
    end_run();

    // Resync two edges before the third tick
    start_run(4, 128, 2, s);
    while (cyc < s + 10) step();
    resync = 1'b1;
    push_ticks(s + 11, 4, 128, 5);
    step();
    resync = 1'b0;
    drain("resync", 60);
    end_run();

    // rx_done together with resync on the edge a tick is due
    start_run(4, 128, 1, s);
    while (cyc < s + 7) step();
    rx_done = 1'b1;
    resync  = 1'b1;
    step();
    rx_done = 1'b0;
    resync  = 1'b0;
    chk("done_resync_busy", b4.busy, 0);
    repeat (12) step();
    chk("done_resync_pending", q1.size(), 0);

    // rx_start with rx_done in IDLE enters RUN; cfg_load in RUN is ignored
    rx_done = 1'b1;
    start_run(4, 128, 8, s);
    rx_done = 1'b0;
    step();
    load({16'd10, 8'd0});
    drain("load_in_run", 80);
    end_run();
    start_run(4, 128, 3, s);
    drain("after_ignored_load", 40);
    end_run();

    // Integer part 1 clamps to 2
    load({16'd1, 8'd0});
    start_run(2, 0, 6, s);
    for (int j = 1; j <= 8; j++) begin
      step();
      chk("clamp_strobe", b4.sample_tick, (j % 2 == 0) ? 1 : 0);
    end
    drain("clamp", 20);
    end_run();

    // Reset mid-frame while a tick strobe is high
    sel = 0;
    load({16'd7, 8'd0});
    start_run(7, 0, 2, s);
    drain("pre_reset", 40);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy9", b9.busy, 0);
    chk("arst_tick9", b9.sample_tick, 0);
    chk("arst_phase9", b9.phase, 0);
    chk("arst_mid9", b9.mid_tick, 0);
    chk("arst_bit9", b9.bit_tick, 0);
    step();
    step();
    rst = 1'b0;
    q0.delete();
    q1.delete();
    step();
    start_run(578, 180, 2, s);
    drain("post_reset_default", 1300);
    end_run();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx_tick_gen.md
# uart_rx_tick_gen

Parametrised oversampling tick generator for the UART receive path. It replaces a fixed 9x, integer-only sample-clock divider with a runtime-loadable fixed-point divisor, a configurable oversampling ratio, phase tracking, mid-bit and end-of-bit strobes, and start-edge re-synchronisation. It sits between the RX line edge detector, which drives `rx_start` and `resync`, and the RX bit/frame state machine, which consumes the ticks and drives `rx_done`.

## Interface
- `CLK_FREQUENCE`, 50_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 9600: baud rate used to compute the reset-time divisor.
- `OSR`, 9: sample ticks per bit, legal range 4..16.
- `FRAC_W`, 8: fractional bits of the divisor.
- `DIV_W`, 16: integer bits of the divisor.

- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `rx_start`  in  1  start of frame; level-sampled in IDLE.
- `rx_done`  in  1  end of frame; returns the block to IDLE.
- `resync`  in  1  re-align the tick phase in RUN (start-edge seen).
- `cfg_load`  in  1  load `cfg_div`; honoured in IDLE only.
- `cfg_div`  in  DIV_W+FRAC_W  clocks per sample tick, unsigned fixed point, integer part I, fraction F.
- `busy`  out  1  high in RUN.
- `sample_tick`  out  1  one-cycle pulse at each oversample point.
- `mid_tick`  out  1  `sample_tick` && `phase` == OSR/2 (integer division).
- `bit_tick`  out  1  `sample_tick` && `phase` == OSR-1.
- `phase`  out  $clog2(OSR)  index of the current tick within the bit; valid while `sample_tick` is high.

## Operation
- DEF_DIV = round(CLK_FREQUENCE·2^FRAC_W / (BAUD_RATE·OSR)). With the defaults this is 148148 (I=578, F=180).
- Registers: `div_reg` (reset DEF_DIV), `cnt`, `frac_acc` (FRAC_W bits), `carry`, `phase_cnt`, `state`.
- FSM has two states, IDLE and RUN.
  - IDLE→RUN on `rx_start`. On entry, `cnt`, `frac_acc`, `carry` and `phase_cnt` are cleared.
  - RUN→IDLE on `rx_done`. All counters clear and no tick is issued on that edge.
  - `rx_start` is ignored in RUN.
- In RUN, period length P = I + `carry`.
  - When `cnt` == P-1: `cnt`←0, `sample_tick`←1, `phase_cnt`←(`phase_cnt`+1) mod OSR, and {`carry`,`frac_acc`}←`frac_acc`+F.
  - Otherwise `cnt`←`cnt`+1.
- `phase` shows the pre-increment `phase_cnt`, so the first tick has `phase` 0.
- `resync` in RUN clears `cnt`, `frac_acc`, `carry` and `phase_cnt`, and suppresses any tick due on that edge.
- `cfg_load` in IDLE sets `div_reg`←`cfg_div`, with I clamped to a minimum of 2. `cfg_load` is ignored in RUN.
- Priority order: `rst` > `rx_done` > `resync` > tick. In IDLE, `rx_start` with `rx_done` in the same cycle enters RUN. `cfg_load` with `rx_start` in IDLE loads first, and the new divisor applies to the first period.

## Timing
- All outputs are registered.
- Reset values: `busy` 0, `sample_tick` 0, `mid_tick` 0, `bit_tick` 0, `phase` 0, `div_reg` DEF_DIV.
- Asserting `rst` mid-frame drops all outputs to 0 asynchronously.
- If `rx_start` is sampled at edge 0, `busy` is high after edge 0 and the first `sample_tick` is high in the cycle after edge I.
- Tick spacing is I or I+1 cycles. Over 2^FRAC_W ticks the total is exactly 2^FRAC_W·I + F·... cycles, i.e. zero long-term drift.
- `bit_tick` occurs every OSR ticks. `mid_tick` occurs OSR/2 ticks after each bit boundary.
- After `resync` at edge k, the next tick is high in the cycle after edge k+I.
- Each tick strobe is exactly 1 cycle wide. Ticks are never back-to-back because I ≥ 2.

## Structure
- Package `uart_pkg` holds:
  - state enum {IDLE, RUN};
  - function `calc_def_div(clk_hz, baud, osr, frac_w)`;
  - width constants `PHASE_W = $clog2(OSR)` and `DIVW_T = DIV_W+FRAC_W`.
- Sub-module `uart_frac_divider` holds `cnt`, `frac_acc` and `carry`. It has inputs `clr`, `en`, I and F, and outputs a raw tick. The top level contains the FSM, the phase counter and the strobe decode.

## Test plan
- Defaults, reset then `rx_start`: first tick 578 cycles after start. Over 256 ticks, 180 periods are 579 cycles and 76 are 578; `bit_tick` on every 9th tick; `mid_tick` at `phase` 4.
- `cfg_div` = I 4, F 128, OSR 4: tick periods 4,4,5,4,5,…; `phase` sequence 0,1,2,3; `mid_tick` at 2; `bit_tick` at 3.
- `resync` asserted 2 cycles before a due tick: that tick is suppressed, the next tick comes I cycles later with `phase` 0, and `frac_acc` is 0.
- `rx_done` and `resync` in the same cycle: IDLE, `busy` 0, no tick. `rx_start` with `rx_done` in IDLE enters RUN.
- `cfg_load` in RUN with I=10 is ignored. In IDLE with I=1 the clamp applies, giving period 2 and 1-cycle strobes separated by 1 low cycle.
- `rst` pulsed mid-frame: all outputs 0 immediately and `div_reg` returns to 148148.
